// File: rtl/clk_div_pkg.sv
// Shared constants, request encoding and divisor helpers for the clk_div_n divider.
// Helper functions take 32-bit arguments, so WIDTH is limited to 32 bits.
package clk_div_pkg;

  localparam int CLK_DIV_DEFAULT_WIDTH = 8;

  // Decoded form of a divisor load request in the current cycle.
  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_STAGE  = 2'd1,
    CFG_REJECT = 2'd2
  } cfg_req_e;

  // Cycles clk_out spends high per period: ceil(N/2).
  function automatic logic [31:0] high_time(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

  function automatic logic is_valid_div(input logic [31:0] n);
    return (n != 32'd0);
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor configuration for clk_div_n: pending/active divisor registers,
// same-cycle bypass at period boundaries and rejection of a zero divisor.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = CLK_DIV_DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boundary,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH-1:0] div_active,
  output logic [WIDTH-1:0] div_next,
  output logic             div_pending,
  output logic             cfg_err,
  output logic             apply
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  cfg_req_e         req;
  logic [WIDTH-1:0] pend_val;

  always_comb begin
    req = CFG_IDLE;
    if (div_load) begin
      req = is_valid_div(32'(div_in)) ? CFG_STAGE : CFG_REJECT;
    end
  end

  // A load arriving on the boundary itself wins over an older pending value.
  always_comb begin
    div_next = div_active;
    apply    = 1'b0;
    if (boundary) begin
      if (req == CFG_STAGE) begin
        div_next = div_in;
        apply    = 1'b1;
      end else if (div_pending) begin
        div_next = pend_val;
        apply    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_active  <= DEF_DIV;
      pend_val    <= DEF_DIV;
      div_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err    <= (req == CFG_REJECT);
      div_active <= div_next;
      if (boundary) begin
        div_pending <= 1'b0;
      end else if (req == CFG_STAGE) begin
        pend_val    <= div_in;
        div_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable divide-by-N clock divider producing a near-50% clk_out,
// a period-start tick strobe and the current phase count.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = CLK_DIV_DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             terminal;
  logic             boundary;
  logic             apply;
  logic [WIDTH-1:0] div_next;
  logic [WIDTH-1:0] clr_div;
  logic [WIDTH-1:0] high;
  logic [WIDTH-1:0] count_inc;

  // clr outranks en, so a cleared cycle is never also treated as a wrap.
  assign terminal  = (count == div_active - ONE);
  assign boundary  = clr | (en & terminal);
  assign clr_div   = apply ? div_next : div_active;
  assign high      = WIDTH'(high_time(32'(div_active)));
  assign count_inc = count + ONE;

  clk_div_cfg #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .boundary    (boundary),
    .div_load    (div_load),
    .div_in      (div_in),
    .div_active  (div_active),
    .div_next    (div_next),
    .div_pending (div_pending),
    .cfg_err     (cfg_err),
    .apply       (apply)
  );

  // Reset and clr park the phase on the terminal count so the next enabled edge starts a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= DEF_DIV - ONE;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (clr) begin
      count   <= clr_div - ONE;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        count   <= '0;
        clk_out <= 1'b1;
        tick    <= 1'b1;
      end else begin
        count   <= count_inc;
        clk_out <= (count_inc < high);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
- Parametrised, fully synchronous integer clock divider. Generalises the fixed divide-by-11 counter to a runtime-programmable divide-by-N.
- Produces a near-50% divided clock (`clk_out`) and a single-cycle terminal-count strobe (`tick`) for clock-enable use.
- Supports glitch-free divisor reload at period boundaries, pause/resume, and phase re-alignment.
- Sits beside timer and baud-generation logic as the shared divider primitive.

Parameters:
- `WIDTH`, 8: width of the divisor and counter.
- `DEFAULT_DIV`, 11: divisor active after reset. Must satisfy 1 <= `DEFAULT_DIV` <= 2^`WIDTH`-1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable. When low, all state holds.
- `clr` in 1: synchronous phase re-align.
- `div_load` in 1: one-cycle request to load `div_in`.
- `div_in` in `WIDTH`: requested divisor N.
- `clk_out` out 1: registered divided clock.
- `tick` out 1: registered one-cycle pulse marking the start of each period.
- `count` out `WIDTH`: current phase, 0..N-1.
- `div_active` out `WIDTH`: divisor currently in force.
- `div_pending` out 1: a loaded divisor is waiting for the next wrap.
- `cfg_err` out 1: one-cycle pulse on a rejected load.

Behaviour:
- Priority, highest first: `rst`, then `clr`, then `en`. `div_load`/`cfg_err` handling is independent of `en`.
- Reset values:
  - `count` = `DEFAULT_DIV`-1
  - `div_active` = `DEFAULT_DIV`
  - `clk_out` = 0, `tick` = 0
  - `div_pending` = 0, `cfg_err` = 0
- High time: H = N - floor(N/2), i.e. `clk_out` is high for ceil(N/2) cycles and low for floor(N/2) cycles.
- Enabled edge, not at terminal count (`count` != N-1):
  - `count` <= `count`+1
  - `clk_out` <= (`count`+1 < H)
  - `tick` <= 0
- Enabled edge, at terminal count (the "wrap"):
  - `count` <= 0 and `tick` <= 1.
  - If a divisor is pending, `div_active` <= pending value and `div_pending` <= 0.
  - `clk_out` <= 1.
- Consequence: the first enabled edge after reset wraps immediately. `tick` and the rising edge of `clk_out` coincide, and the first full period starts then.
- `en` = 0: `count`, `clk_out` and `div_active` hold; `tick` <= 0. Resuming continues the same phase, with no extra or short pulse.
- `clr` = 1:
  - `count` <= `div_active`-1, `clk_out` <= 0, `tick` <= 0. This is identical to the post-reset phase.
  - A pending divisor is applied now and `div_pending` <= 0.
- `div_load` with `div_in` != 0:
  - The value is latched as pending and `div_pending` <= 1.
  - A second load before the wrap overwrites the first; last value wins.
- `div_load` in the same cycle as a wrap or `clr`: `div_in` is applied at that wrap/`clr` (bypass) and `div_pending` stays 0.
- `div_load` with `div_in` = 0:
  - Rejected: `cfg_err` <= 1 for one cycle.
  - Pending state and `div_active` are unchanged.
- N=1: `count` stays 0, `clk_out` is constantly 1, `tick` is 1 on every enabled cycle.
- N=2: `clk_out` alternates 1,0; `tick` is high every 2nd cycle.
- The divisor never changes mid-period, so `clk_out` has no runt pulses.
- `clk_out` is driven only from a flop, never by combinational decode.
- `rst` mid-period aborts the period immediately; any pending divisor is lost.
- All outputs are registered.
- All arithmetic is `WIDTH` bits unsigned. The N-1 and `count`+1 compares never overflow because N <= 2^`WIDTH`-1.

Decomposition:
- Package `clk_div_pkg`:
  - constant `CLK_DIV_DEFAULT_WIDTH` = 8
  - function `high_time(N)` returning N - (N>>1)
  - function `is_valid_div(N)`
- Optional sub-module `clk_div_cfg`: holds the pending/active divisor registers, bypass and `cfg_err` logic, and presents `div_active` plus an `apply` strobe.
- The counter and `clk_out` logic stay in `clk_div_n`.

Test Plan:
- Reset with `DEFAULT_DIV`=11, `en`=1 for 33 cycles:
  - `tick` pulses every 11 cycles, starting on the first enabled edge.
  - `clk_out` is high for 6 cycles, low for 5.
  - `count` sequence is 0..10.
- `div_in`=4 loaded at `count`=3 (N=11):
  - `div_pending`=1 until the wrap at `count`=10; the current period finishes at 11 cycles.
  - Afterwards periods are 4 cycles: `clk_out` 1,1,0,0; `div_active`=4.
- `div_in`=0 load: `cfg_err` is a single pulse; `div_active` and period are unchanged; `div_pending` stays 0.
- `en` dropped for 7 cycles at `count`=5: outputs frozen; on resume the period completes with exactly 6 more enabled cycles before `tick`.
- Odd/extreme divisors N=1, 2, 3 and 255 (`WIDTH`=8):
  - N=1: `clk_out` constant 1.
  - N=3: `clk_out` 1,1,0.
  - N=255: high 128, low 127.
- `clr` asserted at `count`=7 with a pending 5: next edge gives `count`=4, `clk_out`=0, `div_active`=5. The following edge wraps with `tick`=1.
- Simultaneous `div_load`(6) on a wrap cycle: `div_active`=6 immediately and the very next period is 6 cycles.
